prefix_addsub_pipe: RTL

//  Parametrised, pipelined add/subtract unit built on the hybrid sparse prefix carry tree
//  (odd-bit Kogge-Stone levels plus one even-bit fix-up level). It adds subtract mode,

---
 rtl/arith_pkg.sv | 37 +++
 rtl/prefix_level.sv | 33 +++
 rtl/prefix_addsub_pipe.sv | 131 +++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : arith_pkg
//  Purpose  : Shared op encodings and pipeline-placement helpers for the
//             sparse prefix add/sub engine.
//  Revision : 1.0
// ============================================================================
package arith_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBB = 2'b11
    } op_e;

    function automatic int num_levels(input int width);
        return $clog2(width) + 1;
    endfunction

    function automatic int stage_level(input int k, input int stages, input int levels);
        return (k * levels) / (stages + 1);
    endfunction

    // Intermediate register stage sitting after prefix level lvl (0 = none).
    // The last stage is always the result register, so only k < stages count here.
    function automatic int reg_stage_at(input int lvl, input int stages, input int levels);
        int hit;
        hit = 0;
        for (int k = 1; k < stages; k++) begin
            if (stage_level(k, stages, levels) == lvl) hit = k;
        end
        return hit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prefix_level.sv
`default_nettype none
// ============================================================================
//  Module   : prefix_level
//  Purpose  : One combinational level of the hybrid sparse prefix tree.
//  Revision : 1.0
// ============================================================================
module prefix_level #(
    parameter int WIDTH = 32,
    parameter int LEVEL = 1,
    parameter bit FINAL = 1'b0
) (
    input  logic [WIDTH-1:0] i_p,
    input  logic [WIDTH-1:0] i_g,
    output logic [WIDTH-1:0] o_p,
    output logic [WIDTH-1:0] o_g
);
    localparam int DIST = FINAL ? 1 : (1 << (LEVEL - 1));

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        // Odd bits build the sparse Kogge-Stone spine; the final level fills even bits.
        localparam bit ACTIVE = FINAL ? ((i > 0) && (i % 2 == 0))
                                      : ((i % 2 == 1) && (i >= DIST));
        if (ACTIVE) begin : g_merge
            assign o_g[i] = i_g[i] | (i_p[i] & i_g[i-DIST]);
            assign o_p[i] = i_p[i] & i_p[i-DIST];
        end else begin : g_pass
            assign o_g[i] = i_g[i];
            assign o_p[i] = i_p[i];
        end
    end

endmodule
`default_nettype wire

// File: rtl/prefix_addsub_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : prefix_addsub_pipe
//  Purpose  : Pipelined add/sub unit on a sparse prefix tree with flags,
//             sideband tag and valid/ready flow control.
//  Revision : 1.0
// ============================================================================
module prefix_addsub_pipe
    import arith_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 1,
    parameter int TAG_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_ci,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_co,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);
    localparam int LEVELS = num_levels(WIDTH);
    localparam int SIDE_W = WIDTH + 1 + TAG_W;
    localparam int RES_W  = WIDTH + 3 + TAG_W;

    logic [WIDTH-1:0]       b_prep;
    logic                   ci_prep;
    logic [PIPE_STAGES:0]   ld;
    logic [RES_W-1:0]       res, res_out;

    always_comb begin
        b_prep  = in_b;
        ci_prep = 1'b0;
        case (in_op)
            OP_SUB: begin b_prep = ~in_b; ci_prep = 1'b1;   end
            OP_ADC: begin                 ci_prep = in_ci;  end
            OP_SBB: begin b_prep = ~in_b; ci_prep = ~in_ci; end
            default: ;
        endcase
    end

    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int STG = reg_stage_at(l, PIPE_STAGES, LEVELS);
        logic [WIDTH-1:0]  p_out, g_out, p_nx, g_nx;
        logic [SIDE_W-1:0] side_cur, side_nx;

        if (l == 0) begin : g_gen
            assign p_out    = in_a ^ b_prep;
            assign g_out    = in_a & b_prep;
            assign side_cur = {in_a ^ b_prep, ci_prep, in_tag};
        end else begin : g_tree
            prefix_level #(.WIDTH(WIDTH), .LEVEL(l), .FINAL(l == LEVELS)) u_level (
                .i_p (g_lvl[l-1].p_nx),
                .i_g (g_lvl[l-1].g_nx),
                .o_p (p_out),
                .o_g (g_out)
            );
            assign side_cur = g_lvl[l-1].side_nx;
        end

        if (STG != 0) begin : g_reg
            logic [2*WIDTH+SIDE_W-1:0] data_d, data_q;
            always_comb data_d = ld[STG-1] ? {p_out, g_out, side_cur} : data_q;
            always_ff @(posedge clk) data_q <= data_d;
            assign {p_nx, g_nx, side_nx} = data_q;
        end else begin : g_thru
            assign {p_nx, g_nx, side_nx} = {p_out, g_out, side_cur};
        end
    end

    logic [WIDTH-1:0] fin_p0, carry, sum;
    logic             fin_ci;
    logic [TAG_W-1:0] fin_tag;

    assign {fin_p0, fin_ci, fin_tag} = g_lvl[LEVELS].side_nx;
    assign carry = g_lvl[LEVELS].g_nx | (g_lvl[LEVELS].p_nx & {WIDTH{fin_ci}});
    assign sum   = fin_p0 ^ {carry[WIDTH-2:0], fin_ci};
    assign res   = {sum, carry[WIDTH-1], carry[WIDTH-1] ^ carry[WIDTH-2], ~|sum, fin_tag};

    if (PIPE_STAGES == 0) begin : g_nopipe
        assign ld        = out_ready;
        assign in_ready  = out_ready;
        assign out_valid = in_valid;
        assign res_out   = res;
    end else begin : g_pipe
        logic [PIPE_STAGES-1:0] v_d, v_q;
        logic [RES_W-1:0]       res_d, res_q;

        // A stage loads when empty or when its successor drains it this cycle.
        always_comb begin
            ld[PIPE_STAGES] = out_ready;
            for (int k = PIPE_STAGES - 1; k >= 0; k--) ld[k] = ~v_q[k] | ld[k+1];
        end

        assign in_ready = rst_n & ~flush & ld[0];

        always_comb begin
            v_d = v_q;
            if (ld[0]) v_d[0] = in_valid & in_ready;
            for (int k = 1; k < PIPE_STAGES; k++) begin
                if (ld[k]) v_d[k] = v_q[k-1];
            end
            if (!rst_n || flush) v_d = '0;
        end

        always_comb res_d = ld[PIPE_STAGES-1] ? res : res_q;

        always_ff @(posedge clk) begin
            v_q   <= v_d;
            res_q <= res_d;
        end

        assign out_valid = v_q[PIPE_STAGES-1];
        assign res_out   = res_q;
    end

    assign {out_sum, out_co, out_ovf, out_zero, out_tag} = out_valid ? res_out : '0;

endmodule
`default_nettype wire
